// File: rtl/fetch_buf_2p_pingpong.sv
// Two-bank ping-pong fetch buffer: the writer fills one bank while the reader drains the other.
// Optional FETCH_BUF_WR_CNT_EN adds per-bank write-beat counters exposed as rd_len.

module rf_2p_be #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] we_n,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Bit-granular write, active-low enable per bit.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH; b++) begin
      if (!we_n[b]) mem[waddr][b] <= wdata[b];
    end
  end

  assign rdata = mem[raddr];

endmodule

module fetch_buf_2p_pingpong #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int PIX_PER_WORD = 8,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PIX_PER_WORD-1:0]             wr_en,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic [PIXEL_WIDTH*PIX_PER_WORD-1:0] wr_data,
  input  logic                                wr_done,
  output logic                                wr_rdy,
  input  logic                                rd_re,
  input  logic [ADDR_WIDTH-1:0]               rd_addr,
  input  logic                                rd_done,
  output logic                                rd_bank_vld,
  output logic [PIXEL_WIDTH*PIX_PER_WORD-1:0] rd_data,
  output logic                                rd_vld,
`ifdef FETCH_BUF_WR_CNT_EN
  output logic [ADDR_WIDTH:0]                 rd_len,
`endif
  output logic                                err_ovf,
  output logic                                err_udf
);

  localparam int DATA_W = PIXEL_WIDTH * PIX_PER_WORD;

  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full;
  logic [1:0]        full_next;
  logic              wr_accept;
  logic              wr_done_ok;
  logic              rd_done_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] we_n;
  logic [DATA_W-1:0] ram_rdata;

  assign wr_rdy      = ~full[wr_bank];
  assign rd_bank_vld = full[rd_bank];

  // Writes are suppressed during reset so a reset mid-fill leaves the RAM untouched.
  assign wr_accept  = wr_rdy & ~rst;
  assign wr_done_ok = wr_done & wr_rdy;
  assign rd_done_ok = rd_done & rd_bank_vld;
  assign rd_ok      = rd_re & rd_bank_vld;

  always_comb begin
    we_n = '1;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      we_n[i*PIXEL_WIDTH +: PIXEL_WIDTH] = {PIXEL_WIDTH{~(wr_accept & wr_en[i])}};
    end
  end

  // A set and a clear can never hit the same bank: wr_done_ok needs it empty, rd_done_ok needs it full.
  always_comb begin
    full_next = full;
    if (wr_done_ok) full_next[wr_bank] = 1'b1;
    if (rd_done_ok) full_next[rd_bank] = 1'b0;
  end

  rf_2p_be #(
    .DATA_WIDTH(DATA_W),
    .ADDR_WIDTH(ADDR_WIDTH + 1)
  ) u_ram (
    .clk   (clk),
    .we_n  (we_n),
    .waddr ({wr_bank, wr_addr}),
    .wdata (wr_data),
    .raddr ({rd_bank, rd_addr}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      rd_vld  <= 1'b0;
      rd_data <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      full    <= full_next;
      if (wr_done_ok) wr_bank <= ~wr_bank;
      if (rd_done_ok) rd_bank <= ~rd_bank;
      rd_vld  <= rd_ok;
      if (rd_ok) rd_data <= ram_rdata;
      err_ovf <= err_ovf | (wr_done & ~wr_rdy);
      err_udf <= err_udf | ((rd_re | rd_done) & ~rd_bank_vld);
    end
  end

`ifdef FETCH_BUF_WR_CNT_EN
  localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0] wr_cnt [2];

  // Banks being written and drained always differ, so increment and clear never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt[0] <= '0;
      wr_cnt[1] <= '0;
    end else begin
      if (wr_accept && (|wr_en) && (wr_cnt[wr_bank] != CNT_MAX)) begin
        wr_cnt[wr_bank] <= wr_cnt[wr_bank] + 1'b1;
      end
      if (rd_done_ok) wr_cnt[rd_bank] <= '0;
    end
  end

  assign rd_len = rd_bank_vld ? wr_cnt[rd_bank] : '0;
`endif

endmodule

// File: tb/tb_fetch_buf_2p_pingpong.sv
// Directed self-checking bench for fetch_buf_2p_pingpong at default parameters.
// Build with +define+FETCH_BUF_WR_CNT_EN to also exercise rd_len.

module tb_fetch_buf_2p_pingpong;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_done;
  logic        wr_rdy;
  logic        rd_re;
  logic [7:0]  rd_addr;
  logic        rd_done;
  logic        rd_bank_vld;
  logic [63:0] rd_data;
  logic        rd_vld;
  logic        err_ovf;
  logic        err_udf;
`ifdef FETCH_BUF_WR_CNT_EN
  logic [8:0]  rd_len;
`endif

  int num_checks = 0;
  int num_fails  = 0;

  always #5 clk = ~clk;

  fetch_buf_2p_pingpong #(
    .PIXEL_WIDTH (8),
    .PIX_PER_WORD(8),
    .ADDR_WIDTH  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .wr_rdy     (wr_rdy),
    .rd_re      (rd_re),
    .rd_addr    (rd_addr),
    .rd_done    (rd_done),
    .rd_bank_vld(rd_bank_vld),
    .rd_data    (rd_data),
    .rd_vld     (rd_vld),
`ifdef FETCH_BUF_WR_CNT_EN
    .rd_len     (rd_len),
`endif
    .err_ovf    (err_ovf),
    .err_udf    (err_udf)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, step past the edge, then return all strobes to idle.
  task automatic applyStimulus(input logic [7:0] en, input logic [7:0] waddr, input logic [63:0] wdata,
                               input logic wdone, input logic re, input logic [7:0] raddr,
                               input logic rdone, input logic rst_in);
    rst     = rst_in;
    wr_en   = en;
    wr_addr = waddr;
    wr_data = wdata;
    wr_done = wdone;
    rd_re   = re;
    rd_addr = raddr;
    rd_done = rdone;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    wr_en   = '0;
    wr_done = 1'b0;
    rd_re   = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] addr, input logic [7:0] en, input logic [63:0] data);
    applyStimulus(en, addr, data, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic read_word(input string tag, input logic [7:0] addr, input logic [63:0] expected);
    applyStimulus(8'h00, 8'd0, 64'd0, 1'b0, 1'b1, addr, 1'b0, 1'b0);
    checkOutput({tag, "_vld"}, {63'd0, rd_vld}, 64'd1);
    checkOutput({tag, "_data"}, rd_data, expected);
  endtask

  task automatic pulse_wr_done();
    applyStimulus(8'h00, 8'd0, 64'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic pulse_rd_done();
    applyStimulus(8'h00, 8'd0, 64'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    applyStimulus(8'h00, 8'd0, 64'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] b;

    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; wr_done = 1'b0;
    rd_re = 1'b0; rd_addr = '0; rd_done = 1'b0;
    do_reset();
    do_reset();

    $display("[TB] reset values");
    checkOutput("rst_wr_rdy",  {63'd0, wr_rdy},      64'd1);
    checkOutput("rst_bank_vld", {63'd0, rd_bank_vld}, 64'd0);
    checkOutput("rst_rd_vld",  {63'd0, rd_vld},      64'd0);
    checkOutput("rst_rd_data", rd_data,              64'd0);
    checkOutput("rst_err_ovf", {63'd0, err_ovf},     64'd0);
    checkOutput("rst_err_udf", {63'd0, err_udf},     64'd0);

    $display("[TB] basic fill and read of bank0");
    for (int k = 0; k < 4; k++) begin
      b = 8'(k + 1);
      write_word(8'(k), 8'hFF, {8{b}});
    end
    checkOutput("t1_bank_vld_pre", {63'd0, rd_bank_vld}, 64'd0);
    pulse_wr_done();
    checkOutput("t1_bank_vld_post", {63'd0, rd_bank_vld}, 64'd1);
    checkOutput("t1_wr_rdy_bank1", {63'd0, wr_rdy}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      b = 8'(k + 1);
      read_word($sformatf("t1_rd%0d", k), 8'(k), {8{b}});
    end
    applyStimulus(8'h00, 8'd0, 64'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("t1_idle_vld", {63'd0, rd_vld}, 64'd0);
    checkOutput("t1_idle_hold", rd_data, 64'h0404040404040404);

    $display("[TB] partial write and ping-pong into bank1");
    write_word(8'd5, 8'hFF, 64'h1111111111111111);
    write_word(8'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
    write_word(8'd0, 8'hFF, 64'h2222222222222222);
    checkOutput("t3_wr_rdy_pre", {63'd0, wr_rdy}, 64'd1);
    pulse_wr_done();
    checkOutput("t3_wr_rdy_full", {63'd0, wr_rdy}, 64'd0);
    write_word(8'd0, 8'hFF, 64'hDEADBEEFDEADBEEF);
    checkOutput("t3_ovf_pre", {63'd0, err_ovf}, 64'd0);
    pulse_wr_done();
    checkOutput("t3_ovf_set", {63'd0, err_ovf}, 64'd1);
    checkOutput("t3_wr_rdy_still0", {63'd0, wr_rdy}, 64'd0);
    pulse_rd_done();
    checkOutput("t3_wr_rdy_freed", {63'd0, wr_rdy}, 64'd1);
    checkOutput("t3_bank_vld", {63'd0, rd_bank_vld}, 64'd1);
    read_word("t2_partial", 8'd5, 64'h11111111AAAAAAAA);
    read_word("t3_dropped", 8'd0, 64'h2222222222222222);
    checkOutput("t3_udf_clear", {63'd0, err_udf}, 64'd0);

    $display("[TB] simultaneous wr_done and rd_done");
    do_reset();
    checkOutput("t4_rst_ovf", {63'd0, err_ovf}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      b = 8'h50 + 8'(k);
      write_word(8'(k), 8'hFF, {8{b}});
    end
    pulse_wr_done();
    write_word(8'd7, 8'hFF, 64'h7777777777777777);
    applyStimulus(8'h00, 8'd0, 64'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("t4_wr_rdy", {63'd0, wr_rdy}, 64'd1);
    checkOutput("t4_bank_vld", {63'd0, rd_bank_vld}, 64'd1);
    checkOutput("t4_err_ovf", {63'd0, err_ovf}, 64'd0);
    checkOutput("t4_err_udf", {63'd0, err_udf}, 64'd0);
    read_word("t4_rd_bank1", 8'd7, 64'h7777777777777777);

    $display("[TB] underflow and mid-fill reset");
    pulse_rd_done();
    checkOutput("t5_bank_vld_empty", {63'd0, rd_bank_vld}, 64'd0);
    checkOutput("t5_udf_pre", {63'd0, err_udf}, 64'd0);
    applyStimulus(8'h00, 8'd0, 64'd0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b0);
    checkOutput("t5_udf_rd_vld", {63'd0, rd_vld}, 64'd0);
    checkOutput("t5_udf_set", {63'd0, err_udf}, 64'd1);
    checkOutput("t5_udf_hold", rd_data, 64'h7777777777777777);
    pulse_rd_done();
    checkOutput("t5_udf_sticky", {63'd0, err_udf}, 64'd1);
    write_word(8'd1, 8'hFF, 64'h6666666666666666);
    applyStimulus(8'hFF, 8'd2, 64'h9999999999999999, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("t5_rst_wr_rdy", {63'd0, wr_rdy}, 64'd1);
    checkOutput("t5_rst_bank_vld", {63'd0, rd_bank_vld}, 64'd0);
    checkOutput("t5_rst_rd_vld", {63'd0, rd_vld}, 64'd0);
    checkOutput("t5_rst_rd_data", rd_data, 64'd0);
    checkOutput("t5_rst_err_udf", {63'd0, err_udf}, 64'd0);
    checkOutput("t5_rst_err_ovf", {63'd0, err_ovf}, 64'd0);
    pulse_wr_done();
    read_word("t5_no_write_in_rst", 8'd2, 64'h5252525252525252);
    read_word("t5_ram_kept", 8'd1, 64'h6666666666666666);

`ifdef FETCH_BUF_WR_CNT_EN
    $display("[TB] write beat counter");
    do_reset();
    for (int k = 0; k < 10; k++) begin
      write_word(8'(k), (k == 4) ? 8'h00 : 8'hFF, 64'(k));
    end
    checkOutput("t6_len_not_vld", {55'd0, rd_len}, 64'd0);
    pulse_wr_done();
    checkOutput("t6_len_9", {55'd0, rd_len}, 64'd9);
    pulse_rd_done();
    checkOutput("t6_len_cleared", {55'd0, rd_len}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
